pressure_adc_sampler: RTL
=========================

# pressure_adc_sampler

- Reads the gripper pressure sensor through a 12-bit SPI ADC (16-clock frame: 4 leading zeros, then 12 data bits MSB first).
- Box-car averages the samples and presents a left-justified 16-bit pressure word with a one-cycle valid strobe.
- Sits directly upstream of the binary-to-decimal/display stage; its `Pressure_value` drives that stage's `Curr_Pressure_value` input.

## Interface

Parameters:
- `CLK_DIV`, default 5: `CLK` cycles per SCLK half-period (100 MHz gives 10 MHz SCLK); must be ≥1.
- `SAMPLE_PERIOD`, default 100000: `CLK` cycles between conversion starts (1 kHz); must be > 33*`CLK_DIV`+2.
- `AVG_LOG2`, default 3: log2 of the averaging window (8 samples); range 0..4.

Ports:
- `CLK` in 1: single system clock; the block uses one clock only.
- `RESET` in 1: asynchronous, active-high reset.
- `ADC_SDATA` in 1: serial data from the ADC.
- `ADC_CS_N` out 1: ADC chip select, active low; reset value 1.
- `ADC_SCLK` out 1: ADC serial clock, idles high; reset value 1.
- `ADC_RAW` out 12: most recent raw conversion; reset value 0.
- `Pressure_value` out 16: averaged value, left-justified as {avg[11:0], 4'b0}; reset value 0.
- `SAMPLE_VALID` out 1: one-cycle pulse when `Pressure_value` updates; reset value 0.

## Operation

- Sample timer: counts 0..`SAMPLE_PERIOD`-1 and wraps. It emits a tick in the cycle it holds `SAMPLE_PERIOD`-1.
- FSM states:
  - S_IDLE: on tick, drive `ADC_CS_N`<=0 and go to S_SETUP. A tick that arrives while the FSM is not in S_IDLE is dropped, not queued.
  - S_SETUP: hold for `CLK_DIV` cycles (CS-to-SCLK quiet time), then go to S_SHIFT.
  - S_SHIFT: run 16 bits. For each bit, `ADC_SCLK` is low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles.
    - `ADC_SDATA` is sampled on the `CLK` edge that drives `ADC_SCLK` high.
    - Bits shift into a 16-bit register MSB first.
    - After the high half of bit 15, drive `ADC_CS_N`<=1 and go to S_DONE.
  - S_DONE: lasts one cycle, then returns to S_IDLE.
    - `ADC_RAW`<=shift[11:0]; shift[15:12] is discarded regardless of value.
    - Sum = acc + shift[11:0], with the accumulator 12+`AVG_LOG2` bits wide (no overflow possible).
    - Sample counter increments. When it reaches 2^`AVG_LOG2`-1: `Pressure_value`<={sum>>`AVG_LOG2`, 4'b0}, `SAMPLE_VALID`<=1, acc<=0, counter<=0.
    - Otherwise acc<=sum.
- Division truncates (floor). Maximum output is 16'hFFF0.
- Reset, including mid-frame:
  - `ADC_CS_N` and `ADC_SCLK` go to 1 immediately (asynchronously).
  - FSM, timer, shift register, accumulator and sample counter clear.
  - The partial frame is discarded; the next conversion starts at the first tick after reset release, with a fresh averaging window.

## Timing

- Tick in cycle T: `ADC_CS_N` falls at T+1.
- First `ADC_SCLK` falling edge at T+1+`CLK_DIV`.
- `ADC_CS_N` rises at T+1+33*`CLK_DIV`.
- `ADC_RAW`, `Pressure_value` and `SAMPLE_VALID` update at T+2+33*`CLK_DIV`. With defaults: CS low T+1, CS high T+166, outputs T+167.
- `SAMPLE_VALID` lasts exactly one cycle, once per 2^`AVG_LOG2` conversions.
- `Pressure_value` holds its value between pulses.
- Conversion starts are exactly `SAMPLE_PERIOD` cycles apart.

## Configuration

- Macro: `PRESSURE_SAMPLER_AVG_EN`.
- Defined: averaging as described above.
- Not defined:
  - Accumulator and sample counter are not built; `AVG_LOG2` is ignored.
  - Every S_DONE sets `Pressure_value`<={shift[11:0],4'b0} and pulses `SAMPLE_VALID`, so there is one pulse per conversion.

## Test plan

- Reset check: assert `RESET` with no clock running → `ADC_CS_N`=1, `ADC_SCLK`=1, `ADC_RAW`=0, `Pressure_value`=0, `SAMPLE_VALID`=0.
- Single frame, macro off, ADC model returns 0x0A5C → `ADC_RAW`=12'hA5C and `Pressure_value`=16'hA5C0 at T+167. Check exactly 16 SCLK falling edges while CS low, and CS low for 165 cycles.
- Macro on, 8 frames of 0x800 → no `SAMPLE_VALID` for frames 1-7; a single pulse after frame 8 with `Pressure_value`=16'h8000.
- Macro on, frames alternating 0xFFF/0x000 ×8 → `Pressure_value`=16'h7FF0 (floor of 16380/8 = 0x7FF). Next window of all 0xFFF → 16'hFFF0.
- Model drives the 4 leading bits as 1 with data 0x123 → `ADC_RAW`=12'h123; the leading bits are ignored.
- Assert `RESET` during bit 7 of S_SHIFT → CS_N and SCLK high in the same cycle and no `SAMPLE_VALID`. After release, 8 frames of 0x400 → `Pressure_value`=16'h4000, showing no contamination from the pre-reset window.

Source files
------------

// File: rtl/pressure_adc_sampler.sv
`default_nettype none
// ============================================================================
// Module   : pressure_adc_sampler
// Purpose  : Reads a 12-bit SPI ADC (16-clock frame: 4 leading zeros, then
//            12 data bits MSB first) on a fixed sample period. Presents a
//            left-justified 16-bit pressure word with a one-cycle valid strobe.
// Options  : PRESSURE_SAMPLER_AVG_EN - when defined, samples are box-car
//            averaged over 2**AVG_LOG2 conversions before being presented.
//            When undefined, every conversion is presented directly.
// Revision : 1.0 - initial release
// ============================================================================
module pressure_adc_sampler #(
  parameter int CLK_DIV       = 5,
  parameter int SAMPLE_PERIOD = 100000,
  parameter int AVG_LOG2      = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ADC_SDATA,
  output logic        ADC_CS_N,
  output logic        ADC_SCLK,
  output logic [11:0] ADC_RAW,
  output logic [15:0] Pressure_value,
  output logic        SAMPLE_VALID
);

  localparam int c_TMR_W = $clog2(SAMPLE_PERIOD);
  localparam int c_DIV_W = $clog2(CLK_DIV + 1);

  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(SAMPLE_PERIOD - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_SETUP = 2'd1;
  localparam logic [1:0] c_S_SHIFT = 2'd2;
  localparam logic [1:0] c_S_DONE  = 2'd3;

  logic [c_TMR_W-1:0] r_timer;
  logic               w_tick;
  logic [1:0]         r_state;
  logic [c_DIV_W-1:0] r_div;
  logic               w_half_end;
  logic [3:0]         r_bit;
  logic [15:0]        r_shift;
  logic               r_cs_n;
  logic               r_sclk;
  logic [11:0]        r_raw;
  logic [15:0]        r_pressure;
  logic               r_valid;
  logic               w_unused;

  // The four leading frame bits carry no data and are dropped on the floor.
  assign w_unused   = ^r_shift[15:12];

  assign w_tick     = (r_timer == c_TMR_LAST);
  assign w_half_end = (r_div == c_DIV_LAST);

  // Free-running sample timer; its wrap cycle is the conversion start tick.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_timer <= '0;
    end else if (w_tick) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + c_TMR_W'(1);
    end
  end

  // Frame sequencer: chip select, SCLK generation and MSB-first shift-in.
  // A tick outside S_IDLE is simply ignored, so overlapping starts are dropped.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= c_S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b1;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          r_div <= '0;
          r_bit <= '0;
          if (w_tick) begin
            r_cs_n  <= 1'b0;
            r_state <= c_S_SETUP;
          end
        end
        c_S_SETUP: begin
          if (w_half_end) begin
            r_div   <= '0;
            r_sclk  <= 1'b0;
            r_state <= c_S_SHIFT;
          end else begin
            r_div <= r_div + c_DIV_W'(1);
          end
        end
        c_S_SHIFT: begin
          if (w_half_end) begin
            r_div <= '0;
            if (!r_sclk) begin
              // Rising SCLK edge: capture the bit the ADC set up on the fall.
              r_sclk  <= 1'b1;
              r_shift <= {r_shift[14:0], ADC_SDATA};
            end else if (r_bit == 4'd15) begin
              // SCLK is left high so it idles high after the frame.
              r_cs_n  <= 1'b1;
              r_state <= c_S_DONE;
            end else begin
              r_sclk <= 1'b0;
              r_bit  <= r_bit + 4'd1;
            end
          end else begin
            r_div <= r_div + c_DIV_W'(1);
          end
        end
        c_S_DONE: begin
          r_state <= c_S_IDLE;
        end
        default: begin
          r_state <= c_S_IDLE;
        end
      endcase
    end
  end

`ifdef PRESSURE_SAMPLER_AVG_EN
  localparam int         c_ACC_W    = 12 + AVG_LOG2;
  localparam logic [3:0] c_CNT_LAST = 4'((1 << AVG_LOG2) - 1);

  logic [c_ACC_W-1:0] r_acc;
  logic [3:0]         r_cnt;
  logic [c_ACC_W-1:0] w_sum;
  logic [11:0]        w_avg;
  logic               w_window_end;

  // The accumulator is wide enough for a full window of 12'hFFF samples.
  assign w_sum        = r_acc + c_ACC_W'(r_shift[11:0]);
  assign w_avg        = w_sum[c_ACC_W-1:AVG_LOG2];
  assign w_window_end = (r_cnt == c_CNT_LAST);

  // Window accumulator and sample counter, advanced once per finished frame.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == c_S_DONE) begin
      if (w_window_end) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end
`endif

  // Output registers: raw sample every frame, pressure word plus strobe per window.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_raw      <= '0;
      r_pressure <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_state == c_S_DONE) begin
        r_raw <= r_shift[11:0];
`ifdef PRESSURE_SAMPLER_AVG_EN
        if (w_window_end) begin
          r_pressure <= {w_avg, 4'b0000};
          r_valid    <= 1'b1;
        end
`else
        r_pressure <= {r_shift[11:0], 4'b0000};
        r_valid    <= 1'b1;
`endif
      end
    end
  end

  assign ADC_CS_N       = r_cs_n;
  assign ADC_SCLK       = r_sclk;
  assign ADC_RAW        = r_raw;
  assign Pressure_value = r_pressure;
  assign SAMPLE_VALID   = r_valid;

endmodule
`default_nettype wire
